// File: rtl/fpm_exp.sv
// fpm_exp: exponent sequencer for the floating-point microoperation path.
// Aligns operand exponents (AF/SF), steps mantissa normalisation and combines
// exponents for MF/DF, driving the shift strobes of the T/C/M mantissa registers.
// Optional feature: define FPM_EXP_BYTESHIFT_EN to let alignment use the
// eight-bit right shift strobe sh_8 while eight or more positions remain.
module fpm_exp #(
    parameter int EXP_W     = 8,
    parameter int MANT_BITS = 40,
    parameter int CNT_W     = 6
) (
    input  logic                    clk_sys,
    input  logic                    _0_f,
    input  logic                    start_al,
    input  logic                    start_nm,
    input  logic                    start_md,
    input  logic                    op_div,
    input  logic signed [EXP_W-1:0] ea,
    input  logic signed [EXP_W-1:0] eb,
    input  logic                    m_norm,
    input  logic                    m_zero,
    input  logic                    m_ovf,
    output logic                    sh_r,
    output logic                    sh_l,
    output logic                    sh_8,
    output logic                    wdt,
    output logic                    g,
    output logic                    wt,
    output logic                    wc,
    output logic signed [EXP_W-1:0] e,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf,
    output logic                    unf,
    output logic                    fz
);

    // Two guard bits so sums/differences of two exponents never wrap.
    localparam int XW = EXP_W + 2;

    localparam logic signed [XW-1:0]    EXP_MAX_X = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0]    EXP_MIN_X = XW'(-(1 << (EXP_W - 1)));
    localparam logic signed [XW-1:0]    MANT_X    = XW'(MANT_BITS);
    localparam logic signed [EXP_W-1:0] EXP_MAX_E = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic signed [EXP_W-1:0] EXP_MIN_E = {1'b1, {(EXP_W-1){1'b0}}};
    localparam logic signed [EXP_W-1:0] ONE_E     = EXP_W'(1);
    localparam logic [CNT_W-1:0]        MANT_C    = CNT_W'(MANT_BITS);
    localparam logic [CNT_W-1:0]        ONE_C     = CNT_W'(1);
`ifdef FPM_EXP_BYTESHIFT_EN
    localparam logic [CNT_W-1:0]        BYTE_C    = CNT_W'(8);
`endif

    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_NORM, S_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic signed [XW-1:0] diff_x;
    logic signed [XW-1:0] mag_x;
    logic signed [XW-1:0] md_x;
    logic             at_max;
    logic             at_min;

    function automatic logic signed [XW-1:0] sext(input logic signed [EXP_W-1:0] x);
        return XW'(x);
    endfunction

    // {overflow, underflow} of a widened exponent against the EXP_W range.
    function automatic logic [1:0] range_chk(input logic signed [XW-1:0] x);
        return {x > EXP_MAX_X, x < EXP_MIN_X};
    endfunction

    // Operand arithmetic, range edges of the running exponent and counter steps.
    always_comb begin
        diff_x  = sext(ea) - sext(eb);
        mag_x   = diff_x[XW-1] ? -diff_x : diff_x;
        md_x    = op_div ? (sext(ea) - sext(eb)) : (sext(ea) + sext(eb));
        at_max  = (e == EXP_MAX_E);
        at_min  = (e == EXP_MIN_E);
        cnt_inc = cnt + ONE_C;
`ifdef FPM_EXP_BYTESHIFT_EN
        cnt_nxt = (cnt >= BYTE_C) ? (cnt - BYTE_C) : (cnt - ONE_C);
`else
        cnt_nxt = cnt - ONE_C;
`endif
    end

    // Shift strobes: decoded from state so they follow the mantissa flags in the
    // same cycle and vanish as soon as reset forces IDLE.
    always_comb begin
        sh_r = 1'b0;
        sh_l = 1'b0;
        sh_8 = 1'b0;
        case (state)
            S_ALIGN: begin
`ifdef FPM_EXP_BYTESHIFT_EN
                if (cnt >= BYTE_C) sh_8 = 1'b1;
                else               sh_r = (cnt != '0);
`else
                sh_r = (cnt != '0);
`endif
            end
            S_NORM: begin
                if (!m_zero) begin
                    if (m_ovf)        sh_r = !at_max;
                    else if (!m_norm) sh_l = !at_min;
                end
            end
            default: ;
        endcase
    end

    // Sequencer: start arbitration, alignment countdown, normalisation stepping.
    always_ff @(posedge clk_sys or posedge _0_f) begin
        if (_0_f) begin
            state <= S_IDLE;
            cnt   <= '0;
            e     <= '0;
            {wdt, g, wt, wc, ovf, unf, fz} <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_al || start_nm || start_md) begin
                        {wdt, g, wt, wc, ovf, unf, fz} <= '0;
                        cnt <= '0;
                    end
                    if (start_al) begin
                        e   <= diff_x[XW-1] ? eb : ea;
                        wdt <= diff_x[XW-1];
                        if (diff_x == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (mag_x >= MANT_X) begin
                            g     <= 1'b1;
                            wt    <= !diff_x[XW-1];
                            wc    <= diff_x[XW-1];
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            cnt   <= mag_x[CNT_W-1:0];
                            state <= S_ALIGN;
                            busy  <= 1'b1;
                        end
                    end else if (start_nm) begin
                        e     <= ea;
                        state <= S_NORM;
                        busy  <= 1'b1;
                    end else if (start_md) begin
                        e          <= md_x[EXP_W-1:0];
                        {ovf, unf} <= range_chk(md_x);
                        state      <= S_DONE;
                        done       <= 1'b1;
                    end
                end
                S_ALIGN: begin
                    cnt <= cnt_nxt;
                    if (cnt_nxt == '0) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_NORM: begin
                    if (m_zero) begin
                        fz    <= 1'b1;
                        e     <= '0;
                        state <= S_DONE;
                    end else if (m_ovf) begin
                        if (at_max) begin
                            ovf   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            e <= e + ONE_E;
                        end
                    end else if (m_norm) begin
                        state <= S_DONE;
                    end else if (at_min) begin
                        unf   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        e   <= e - ONE_E;
                        cnt <= cnt_inc;
                        if (cnt_inc == MANT_C) begin
                            fz    <= 1'b1;
                            e     <= '0;
                            state <= S_DONE;
                        end
                    end
                    // Any exit from NORM lands in DONE with the pulse raised.
                    if (m_zero || (m_ovf && at_max) || (!m_ovf && m_norm) ||
                        (!m_ovf && !m_norm && (at_min || cnt_inc == MANT_C))) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpm_exp.sv
// tb_fpm_exp: randomized and directed checks of the fpm_exp exponent sequencer
// against an arithmetic reference model of alignment, normalisation and MF/DF.
`timescale 1ns/1ps
module tb_fpm_exp;

    localparam int EXP_W     = 8;
    localparam int MANT_BITS = 40;
    localparam int CNT_W     = 6;
    localparam int LIMIT     = 100;

    logic                    clk_sys = 1'b0;
    logic                    _0_f    = 1'b1;
    logic                    start_al = 1'b0, start_nm = 1'b0, start_md = 1'b0;
    logic                    op_div = 1'b0;
    logic signed [EXP_W-1:0] ea = '0, eb = '0;
    logic                    m_norm = 1'b0, m_zero = 1'b0, m_ovf = 1'b0;
    logic                    sh_r, sh_l, sh_8, wdt, g, wt, wc, busy, done, ovf, unf, fz;
    logic signed [EXP_W-1:0] e;

    int n_tests = 0;
    int n_fail  = 0;

    fpm_exp #(.EXP_W(EXP_W), .MANT_BITS(MANT_BITS), .CNT_W(CNT_W)) dut (
        .clk_sys(clk_sys), ._0_f(_0_f),
        .start_al(start_al), .start_nm(start_nm), .start_md(start_md),
        .op_div(op_div), .ea(ea), .eb(eb),
        .m_norm(m_norm), .m_zero(m_zero), .m_ovf(m_ovf),
        .sh_r(sh_r), .sh_l(sh_l), .sh_8(sh_8),
        .wdt(wdt), .g(g), .wt(wt), .wc(wc), .e(e),
        .busy(busy), .done(done), .ovf(ovf), .unf(unf), .fz(fz)
    );

    always #5 clk_sys = ~clk_sys;

    // Flag vector order: {wdt, g, wt, wc, ovf, unf, fz}
    task automatic model_align(input int a, input int b, output int xe, output logic [6:0] fl,
                               output int nr, output int n8, output int d);
        int df, ad;
        df = a - b;
        ad = (df < 0) ? -df : df;
        xe = (a > b) ? a : b;
        fl = '0;
        fl[6] = (df < 0);
        nr = 0;
        n8 = 0;
        d  = 1;
        if (df != 0 && ad >= MANT_BITS) begin
            fl[5] = 1'b1;
            fl[4] = (df > 0);
            fl[3] = (df < 0);
        end else if (df != 0) begin
`ifdef FPM_EXP_BYTESHIFT_EN
            n8 = ad / 8;
            nr = ad % 8;
`else
            nr = ad;
`endif
            d = n8 + nr + 1;
        end
    endtask

    task automatic model_norm(input int a, input int lz, input bit mz, input bit mo,
                              output int xe, output logic [6:0] fl,
                              output int nr, output int nl, output int d);
        int em, ml;
        bit stop, cnt_end;
        em = a; fl = '0; nr = 0; nl = 0; stop = 0; cnt_end = 0; ml = lz;
        if (mz) begin
            fl[0] = 1'b1; em = 0; stop = 1;
        end
        if (!stop && mo) begin
            if (em == 127) begin fl[2] = 1'b1; stop = 1; end
            else begin em = em + 1; nr = 1; end
        end
        while (!stop && ml > 0) begin
            if (em == -128) begin
                fl[1] = 1'b1; stop = 1;
            end else begin
                em = em - 1; nl = nl + 1; ml = ml - 1;
                if (nl == MANT_BITS) begin fl[0] = 1'b1; em = 0; stop = 1; cnt_end = 1; end
            end
        end
        d  = cnt_end ? (nr + nl + 1) : (nr + nl + 2);
        xe = em;
    endtask

    task automatic model_md(input int a, input int b, input logic opd,
                            output int xe, output logic [6:0] fl);
        int s;
        s  = opd ? (a - b) : (a + b);
        fl = '0;
        fl[2] = (s > 127);
        fl[1] = (s < -128);
        xe = s;
    endtask

    // Drives one sequence and records what the DUT does until its done pulse.
    task automatic run_seq(input logic [2:0] starts, input int a, input int b, input logic opd,
                           input int lz_in, input bit mz_in, input bit mo_in, input bit poke,
                           output int obs_d, output int n_r, output int n_l, output int n_8,
                           output int bad, output logic done_again,
                           output logic signed [EXP_W-1:0] obs_e, output logic [6:0] obs_fl);
        int lz, c;
        bit mz, mo;
        lz = lz_in; mz = mz_in; mo = mo_in;
        obs_d = -1; n_r = 0; n_l = 0; n_8 = 0; bad = 0; obs_e = '0; obs_fl = '0;
        @(posedge clk_sys); #1;
        start_al = starts[0]; start_nm = starts[1]; start_md = starts[2];
        ea = a[EXP_W-1:0]; eb = b[EXP_W-1:0]; op_div = opd;
        m_zero = mz; m_ovf = mo; m_norm = (lz == 0) && !mz;
        @(posedge clk_sys); #1;
        c = 1;
        while (c <= LIMIT) begin
            start_al = poke && (c == 1);
            start_nm = poke && (c == 1);
            start_md = poke && (c == 1);
            m_zero = mz; m_ovf = mo; m_norm = (lz == 0) && !mz;
            #1;
            if ($countones({sh_r, sh_l, sh_8}) > 1) bad++;
            if (done && (sh_r || sh_l || sh_8 || busy)) bad++;
            if ((sh_r || sh_l || sh_8) && !busy) bad++;
            n_r += int'(sh_r); n_l += int'(sh_l); n_8 += int'(sh_8);
            if (sh_l && lz > 0) lz--;
            if (sh_r) mo = 0;
            if (done) begin
                obs_d  = c;
                obs_e  = e;
                obs_fl = {wdt, g, wt, wc, ovf, unf, fz};
                break;
            end
            @(posedge clk_sys); #1;
            c++;
        end
        start_al = 0; start_nm = 0; start_md = 0;
        @(posedge clk_sys); #1;
        done_again = done;
    endtask

    task automatic test_reset();
        _0_f = 1'b1;
        @(posedge clk_sys); #1;
        n_tests++;
        if ({sh_r, sh_l, sh_8, wdt, g, wt, wc, ovf, unf, fz, busy, done} !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want 0",
                     {sh_r, sh_l, sh_8, wdt, g, wt, wc, ovf, unf, fz, busy, done});
        end
        n_tests++;
        if (e !== '0) begin n_fail++; $display("FAIL reset_e got %0d want 0", e); end
        _0_f = 1'b0;
    endtask

    task automatic test_align(input int a, input int b, input logic [2:0] st, input bit poke);
        int xe, xr, x8, xd, od, nr, nl, n8, bad;
        logic [6:0] xfl, ofl;
        logic signed [EXP_W-1:0] oe, xe8;
        logic dag;
        model_align(a, b, xe, xfl, xr, x8, xd);
        xe8 = xe[EXP_W-1:0];
        run_seq(st, a, b, 1'b0, 0, 1'b0, 1'b0, poke, od, nr, nl, n8, bad, dag, oe, ofl);
        n_tests++; if (od !== xd) begin n_fail++; $display("FAIL align_done ea=%0d eb=%0d got %0d want %0d", a, b, od, xd); end
        n_tests++; if (nr !== xr) begin n_fail++; $display("FAIL align_shr ea=%0d eb=%0d got %0d want %0d", a, b, nr, xr); end
        n_tests++; if (n8 !== x8) begin n_fail++; $display("FAIL align_sh8 ea=%0d eb=%0d got %0d want %0d", a, b, n8, x8); end
        n_tests++; if (nl !== 0) begin n_fail++; $display("FAIL align_shl ea=%0d eb=%0d got %0d want 0", a, b, nl); end
        n_tests++; if (bad !== 0 || dag !== 1'b0) begin n_fail++; $display("FAIL align_protocol ea=%0d eb=%0d got bad=%0d done_again=%b want 0", a, b, bad, dag); end
        n_tests++; if (ofl !== xfl) begin n_fail++; $display("FAIL align_flags ea=%0d eb=%0d got %b want %b", a, b, ofl, xfl); end
        n_tests++; if (oe !== xe8) begin n_fail++; $display("FAIL align_e ea=%0d eb=%0d got %0d want %0d", a, b, oe, xe8); end
    endtask

    task automatic test_norm(input int a, input int lz, input bit mz, input bit mo,
                             input logic [2:0] st, input bit poke);
        int xe, xr, xl, xd, od, nr, nl, n8, bad;
        logic [6:0] xfl, ofl;
        logic signed [EXP_W-1:0] oe, xe8;
        logic dag;
        model_norm(a, lz, mz, mo, xe, xfl, xr, xl, xd);
        xe8 = xe[EXP_W-1:0];
        run_seq(st, a, 0, 1'b0, lz, mz, mo, poke, od, nr, nl, n8, bad, dag, oe, ofl);
        n_tests++; if (od !== xd) begin n_fail++; $display("FAIL norm_done ea=%0d lz=%0d got %0d want %0d", a, lz, od, xd); end
        n_tests++; if (nl !== xl || nr !== xr || n8 !== 0) begin n_fail++; $display("FAIL norm_shifts ea=%0d lz=%0d got l=%0d r=%0d b=%0d want l=%0d r=%0d b=0", a, lz, nl, nr, n8, xl, xr); end
        n_tests++; if (bad !== 0 || dag !== 1'b0) begin n_fail++; $display("FAIL norm_protocol ea=%0d lz=%0d got bad=%0d done_again=%b want 0", a, lz, bad, dag); end
        n_tests++; if (ofl !== xfl) begin n_fail++; $display("FAIL norm_flags ea=%0d lz=%0d got %b want %b", a, lz, ofl, xfl); end
        if (!xfl[2] && !xfl[1]) begin
            n_tests++; if (oe !== xe8) begin n_fail++; $display("FAIL norm_e ea=%0d lz=%0d got %0d want %0d", a, lz, oe, xe8); end
        end
    endtask

    task automatic test_md(input int a, input int b, input logic opd);
        int xe, od, nr, nl, n8, bad;
        logic [6:0] xfl, ofl;
        logic signed [EXP_W-1:0] oe, xe8;
        logic dag;
        model_md(a, b, opd, xe, xfl);
        xe8 = xe[EXP_W-1:0];
        run_seq(3'b100, a, b, opd, 0, 1'b0, 1'b0, 1'b0, od, nr, nl, n8, bad, dag, oe, ofl);
        n_tests++; if (od !== 1) begin n_fail++; $display("FAIL md_done ea=%0d eb=%0d got %0d want 1", a, b, od); end
        n_tests++; if (nr + nl + n8 + bad !== 0 || dag !== 1'b0) begin n_fail++; $display("FAIL md_protocol ea=%0d eb=%0d got strobes=%0d bad=%0d want 0", a, b, nr + nl + n8, bad); end
        n_tests++; if (ofl !== xfl) begin n_fail++; $display("FAIL md_flags ea=%0d eb=%0d div=%b got %b want %b", a, b, opd, ofl, xfl); end
        if (!xfl[2] && !xfl[1]) begin
            n_tests++; if (oe !== xe8) begin n_fail++; $display("FAIL md_e ea=%0d eb=%0d div=%b got %0d want %0d", a, b, opd, oe, xe8); end
        end
    endtask

    task automatic test_directed();
        test_align(5, 2, 3'b001, 1'b0);
        test_align(-10, 40, 3'b001, 1'b0);
        test_align(19, 0, 3'b001, 1'b0);
        test_align(7, 7, 3'b001, 1'b0);
        test_align(0, 39, 3'b001, 1'b0);
        test_norm(3, 4, 1'b0, 1'b0, 3'b010, 1'b0);
        test_norm(-127, 5, 1'b0, 1'b0, 3'b010, 1'b0);
        test_norm(100, 60, 1'b0, 1'b0, 3'b010, 1'b0);
        test_norm(127, 3, 1'b0, 1'b1, 3'b010, 1'b0);
        test_norm(10, 3, 1'b1, 1'b0, 3'b010, 1'b0);
        test_norm(10, 2, 1'b0, 1'b1, 3'b010, 1'b0);
        test_md(100, 50, 1'b0);
        test_md(100, 50, 1'b1);
        test_md(-100, 50, 1'b1);
        test_md(-64, -64, 1'b0);
    endtask

    task automatic test_priority();
        test_align(9, -4, 3'b011, 1'b0);
        test_align(-20, 1, 3'b111, 1'b0);
        test_norm(12, 3, 1'b0, 1'b0, 3'b110, 1'b0);
    endtask

    task automatic test_busy_ignore();
        test_align(25, 0, 3'b001, 1'b1);
        test_norm(20, 6, 1'b0, 1'b0, 3'b010, 1'b1);
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(posedge clk_sys); #1;
        start_al = 1'b1; ea = 8'sd30; eb = 8'sd0;
        @(posedge clk_sys); #1;
        start_al = 1'b0;
        repeat (4) begin @(posedge clk_sys); #1; end
        n_tests++;
        if ({sh_r | sh_8, busy} !== 2'b11) begin n_fail++; $display("FAIL rstmid_active got %b want 11", {sh_r | sh_8, busy}); end
        #2 _0_f = 1'b1;
        #1;
        n_tests++;
        if ({sh_r, sh_l, sh_8, busy, done, wdt, g, wt, wc, ovf, unf, fz} !== 12'b0) begin
            n_fail++;
            $display("FAIL rstmid_clear got %b want 0", {sh_r, sh_l, sh_8, busy, done, wdt, g, wt, wc, ovf, unf, fz});
        end
        @(posedge clk_sys); #1;
        _0_f = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk_sys); #1;
            seen = seen | done | sh_r | sh_8 | busy;
        end
        n_tests++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet got %b want 0", seen); end
    endtask

    task automatic test_random();
        int a, b, lz;
        for (int i = 0; i < 25; i++) begin
            a = int'($urandom_range(255)) - 128;
            b = (i % 2 == 0) ? a + int'($urandom_range(60)) - 30 : int'($urandom_range(255)) - 128;
            if (b > 127) b = 127;
            if (b < -128) b = -128;
            test_align(a, b, 3'b001, 1'b0);
        end
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(2))
                0:       a = -128 + int'($urandom_range(6));
                1:       a = 127 - int'($urandom_range(1));
                default: a = int'($urandom_range(255)) - 128;
            endcase
            lz = int'($urandom_range(12));
            test_norm(a, lz, ($urandom_range(7) == 0), ($urandom_range(3) == 0), 3'b010, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            test_md(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128, 1'($urandom_range(1)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_priority();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
